tx_beam_pulser: RTL and testbench

- Transmit-side counterpart to the receive beamformer (top_bf): fires one focused transmit event across N_CH transducer elements.
- Each element receives a bipolar pulse train (tx_p/tx_n pair to the HV pulser driver) that starts after a per-channel focusing delay.
- Delays, half-period and cycle count are supplied by the sequencer and latched on start.
- done marks the end of the event, so the sequencer can then start the receive beamformer.

---
 rtl/tx_bf_pkg.sv | 16 +
 rtl/tx_channel_pulser.sv | 100 ++++++++++
 rtl/tx_beam_pulser.sv | 132 +++++++++++++
 tb/tb_tx_beam_pulser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_bf_pkg.sv
// Shared types and default widths for the transmit beam pulser.
// Keeps FSM encodings common to the top level and the testbench.
package tx_bf_pkg;

   localparam int TX_N_CH    = 4;
   localparam int TX_DELAY_W = 8;
   localparam int TX_HP_W    = 8;
   localparam int TX_NC_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FIRE = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/tx_channel_pulser.sv
// One transducer channel: waits for the global timer to reach its delay,
// then emits NC bipolar cycles of HP clocks per half with no dead time.
import tx_bf_pkg::*;

module tx_channel_pulser #(
   parameter int DELAY_W = TX_DELAY_W,
   parameter int HP_W    = TX_HP_W,
   parameter int NC_W    = TX_NC_W
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               en_i,
   input  logic [DELAY_W:0]   t_i,
   input  logic [DELAY_W-1:0] delay_i,
   input  logic [HP_W-1:0]    hp_i,
   input  logic [NC_W-1:0]    nc_i,
   output logic               tx_p_o,
   output logic               tx_n_o,
   output logic               finished_o
);

   logic            fired_q, fired_d;
   logic            p_q, p_d;
   logic            n_q, n_d;
   logic [HP_W-1:0] cnt_q, cnt_d;
   logic [NC_W-1:0] cyc_q, cyc_d;

   logic hp_end;
   logic last_cyc;
   logic last_edge;
   logic hit;

   assign hp_end    = (cnt_q == hp_i);
   assign last_cyc  = (cyc_q == nc_i - NC_W'(1));
   assign last_edge = n_q && hp_end && last_cyc;
   assign hit       = !fired_q && (t_i == {1'b0, delay_i});

   // Finished goes high combinationally on the edge the last tx_n falls,
   // so the top can leave FIRE on that same edge.
   assign finished_o = (fired_q && !p_q && !n_q) || last_edge;

   always_comb begin
      fired_d = fired_q;
      p_d     = p_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      if (clear_i) begin
         fired_d = 1'b0;
         p_d     = 1'b0;
         n_d     = 1'b0;
         cnt_d   = '0;
         cyc_d   = '0;
      end else if (en_i) begin
         if (hit) begin
            fired_d = 1'b1;
            p_d     = 1'b1;
            cnt_d   = HP_W'(1);
            cyc_d   = '0;
         end else if (p_q || n_q) begin
            if (hp_end) begin
               cnt_d = HP_W'(1);
               if (p_q) begin
                  p_d = 1'b0;
                  n_d = 1'b1;
               end else if (last_cyc) begin
                  n_d = 1'b0;
               end else begin
                  n_d   = 1'b0;
                  p_d   = 1'b1;
                  cyc_d = cyc_q + NC_W'(1);
               end
            end else begin
               cnt_d = cnt_q + HP_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fired_q <= 1'b0;
         p_q     <= 1'b0;
         n_q     <= 1'b0;
         cnt_q   <= '0;
         cyc_q   <= '0;
      end else begin
         fired_q <= fired_d;
         p_q     <= p_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
      end
   end

   assign tx_p_o = p_q;
   assign tx_n_o = n_q;

endmodule

// File: rtl/tx_beam_pulser.sv
// Transmit beam pulser: FSM, saturating global timer and latched config,
// driving one tx_channel_pulser per transducer element.
import tx_bf_pkg::*;

module tx_beam_pulser #(
   parameter int N_CH    = TX_N_CH,
   parameter int DELAY_W = TX_DELAY_W,
   parameter int HP_W    = TX_HP_W,
   parameter int NC_W    = TX_NC_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [N_CH*DELAY_W-1:0] delay_flat,
   input  logic [HP_W-1:0]         half_period,
   input  logic [NC_W-1:0]         num_cycles,
   output logic [N_CH-1:0]         tx_p,
   output logic [N_CH-1:0]         tx_n,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              debug_state
);

   state_e state_q, state_d;

   logic [DELAY_W:0]          t_q, t_d;
   logic [N_CH*DELAY_W-1:0]   dly_q, dly_d;
   logic [HP_W-1:0]           hp_q, hp_d;
   logic [NC_W-1:0]           nc_q, nc_d;
   logic                      done_q, done_d;
   logic                      busy_q, busy_d;

   logic                      chan_clr;
   logic                      chan_en;
   logic [N_CH-1:0]           fin;
   logic                      all_fin;

   assign chan_en = (state_q == ST_FIRE);
   assign all_fin = &fin;

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      dly_d    = dly_q;
      hp_d     = hp_q;
      nc_d     = nc_q;
      done_d   = 1'b0;
      chan_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dly_d    = delay_flat;
               hp_d     = half_period;
               nc_d     = num_cycles;
               t_d      = '0;
               chan_clr = 1'b1;
               // A zero-length train has nothing to emit; finish at once.
               if (half_period == '0 || num_cycles == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_FIRE;
               end
            end
         end
         ST_FIRE: begin
            t_d = (&t_q) ? t_q : t_q + (DELAY_W+1)'(1);
            if (abort) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               chan_clr = 1'b1;
            end else if (all_fin) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         t_q     <= '0;
         dly_q   <= '0;
         hp_q    <= '0;
         nc_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         dly_q   <= dly_d;
         hp_q    <= hp_d;
         nc_q    <= nc_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      tx_channel_pulser #(
         .DELAY_W (DELAY_W),
         .HP_W    (HP_W),
         .NC_W    (NC_W)
      ) u_ch (
         .clk_i      (clk),
         .reset_i    (reset),
         .clear_i    (chan_clr),
         .en_i       (chan_en),
         .t_i        (t_q),
         .delay_i    (dly_q[i*DELAY_W +: DELAY_W]),
         .hp_i       (hp_q),
         .nc_i       (nc_q),
         .tx_p_o     (tx_p[i]),
         .tx_n_o     (tx_n[i]),
         .finished_o (fin[i])
      );
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign debug_state = state_q;

endmodule

// File: tb/tb_tx_beam_pulser.sv
// Scoreboard bench for tx_beam_pulser: each event pushes its expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_tx_beam_pulser;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [31:0] delay_flat;
   logic [7:0]  half_period;
   logic [3:0]  num_cycles;
   logic [3:0]  tx_p;
   logic [3:0]  tx_n;
   logic        busy;
   logic        done;
   logic [1:0]  debug_state;

   typedef struct {
      logic [3:0] p;
      logic [3:0] n;
      logic       busy;
      logic       done;
      logic [1:0] st;
      int         k;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    n_vec = 0;
   int    n_bad = 0;
   int    dly[4];
   string cur = "init";

   always #5 clk = ~clk;

   tx_beam_pulser dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .delay_flat  (delay_flat),
      .half_period (half_period),
      .num_cycles  (num_cycles),
      .tx_p        (tx_p),
      .tx_n        (tx_n),
      .busy        (busy),
      .done        (done),
      .debug_state (debug_state)
   );

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         n_vec++;
         if ({tx_p, tx_n, busy, done, debug_state} !==
             {mon_e.p, mon_e.n, mon_e.busy, mon_e.done, mon_e.st}) begin
            n_bad++;
            $display("FAIL %s k=%0d: got p=%b n=%b busy=%b done=%b st=%b, want p=%b n=%b busy=%b done=%b st=%b",
                     cur, mon_e.k, tx_p, tx_n, busy, done, debug_state,
                     mon_e.p, mon_e.n, mon_e.busy, mon_e.done, mon_e.st);
         end
      end
   end

   // Expected outputs after edges E+0 .. E+last+3; cut models an abort.
   function automatic void expect_event(int hp, int nc, int cut);
      int   maxd;
      int   last;
      int   rel;
      exp_t e;
      maxd = 0;
      for (int i = 0; i < 4; i++)
         if (dly[i] > maxd) maxd = dly[i];
      if (hp == 0 || nc == 0) last = 0;
      else last = 1 + maxd + 2 * hp * nc;
      if (cut >= 0 && cut < last) last = cut;
      for (int k = 0; k <= last + 3; k++) begin
         e.p    = '0;
         e.n    = '0;
         e.k    = k;
         e.done = (k == last);
         e.busy = (k <= last);
         e.st   = (k < last) ? 2'b01 : ((k == last) ? 2'b10 : 2'b00);
         if (k < last) begin
            for (int i = 0; i < 4; i++) begin
               rel = k - 1 - dly[i];
               if (rel >= 0 && rel < 2 * hp * nc) begin
                  if (((rel / hp) % 2) == 0) e.p[i] = 1'b1;
                  else e.n[i] = 1'b1;
               end
            end
         end
         sb.push_back(e);
      end
   endfunction

   task automatic fire(input int hp, input int nc);
      @(negedge clk);
      for (int i = 0; i < 4; i++) delay_flat[i*8 +: 8] = dly[i][7:0];
      half_period = hp[7:0];
      num_cycles  = nc[3:0];
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 1000 && sb.size() != 0; c++) @(posedge clk);
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s drain: %0d entries left, want 0", cur, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      cur = "reset";
      @(negedge clk);
      n_vec++;
      if ({tx_p, tx_n, busy, done, debug_state} !== 12'b0) begin
         n_bad++;
         $display("FAIL reset_hold: got %b, want 0", {tx_p, tx_n, busy, done, debug_state});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({tx_p, tx_n, busy, done, debug_state} !== 12'b0) begin
         n_bad++;
         $display("FAIL reset_idle: got %b, want 0", {tx_p, tx_n, busy, done, debug_state});
      end
   endtask

   task automatic test_staggered();
      cur = "staggered";
      dly = '{0, 1, 2, 3};
      fire(2, 1);
      expect_event(2, 1, -1);
      drain();
   endtask

   task automatic test_equal();
      cur = "equal";
      dly = '{5, 5, 5, 5};
      fire(3, 2);
      expect_event(3, 2, -1);
      @(negedge clk);
      delay_flat  = '0;
      half_period = 8'd1;
      num_cycles  = 4'd1;
      drain();
   endtask

   task automatic test_zero_config();
      cur = "zero_hp";
      dly = '{1, 2, 3, 4};
      fire(0, 2);
      expect_event(0, 2, -1);
      drain();
      cur = "zero_nc";
      fire(3, 0);
      expect_event(3, 0, -1);
      drain();
   endtask

   task automatic test_abort();
      cur = "abort";
      dly = '{0, 0, 0, 0};
      fire(4, 3);
      expect_event(4, 3, 3);
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      @(negedge clk) start = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid_fire();
      cur = "reset_mid";
      dly = '{0, 0, 0, 0};
      fire(4, 3);
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (tx_p !== 4'b1111) begin
         n_bad++;
         $display("FAIL reset_mid_pre: got tx_p=%b, want 1111", tx_p);
      end
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if ({tx_p, tx_n, busy, done, debug_state} !== 12'b0) begin
         n_bad++;
         $display("FAIL reset_mid_async: got %b, want 0", {tx_p, tx_n, busy, done, debug_state});
      end
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({tx_p, tx_n, busy, done, debug_state} !== 12'b0) begin
         n_bad++;
         $display("FAIL reset_mid_after: got %b, want 0", {tx_p, tx_n, busy, done, debug_state});
      end
      test_staggered();
   endtask

   task automatic test_max_delay();
      cur = "max_delay";
      dly = '{255, 0, 0, 0};
      fire(1, 1);
      expect_event(1, 1, -1);
      drain();
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      delay_flat  = '0;
      half_period = '0;
      num_cycles  = '0;
      test_reset();
      test_staggered();
      test_equal();
      test_zero_config();
      test_abort();
      test_reset_mid_fire();
      test_max_delay();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
